// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I pipelined control and hazard unit for a 5-stage datapath
//
// Purpose: decodes instr_D into a control word and carries it through E/M/WB.
// Branches resolve in E and redirect the PC from M. Stall/flush are generated
// for RAW and control hazards, since the datapath does not forward.
//
// Ports:
//   clk, reset_D       core clock, async active-high core reset
//   instr_D            instruction held in the Decode register
//   alu_zero_E         ALU result is zero in Execute
//   imm_SEL            D : immediate format (000 I, 001 S, 010 B, 011 U, 100 J)
//   rs1_SEL, rs2_SEL   E : operand A pc select, operand B imm select
//   ALU_SEL            E : {funct7[5],funct3} style ALU op
//   pc_SEL             M : [0] redirect, [1] pc+imm (1) / ALU (0, JALR)
//   mem_WE, mem_RE     M : store / load
//   reg_WE, reg_SEL    WB: regfile write enable, writeback source
//   stall_F, stall_D   hold fetch / decode registers
//   flush_D/E/M        registered clear pulse for the D/E/M registers
//   illegal            sticky: a valid unknown opcode entered Execute
module pipe_ctrl #(
  parameter bit HAZARD_EN = 1'b1,
  parameter int FLUSH_LEN = 1
) (
  input  logic        clk,
  input  logic        reset_D,
  input  logic [31:0] instr_D,
  input  logic        alu_zero_E,
  output logic [2:0]  imm_SEL,
  output logic        rs1_SEL,
  output logic        rs2_SEL,
  output logic [3:0]  ALU_SEL,
  output logic [1:0]  pc_SEL,
  output logic        mem_WE,
  output logic        mem_RE,
  output logic        reg_WE,
  output logic [1:0]  reg_SEL,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic        illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN + 1) : 1;

  // br_inv: branch is taken when alu_zero_E differs from this bit
  typedef struct packed {
    logic       we;
    logic [1:0] wb_sel;
    logic       mem_we;
    logic       mem_re;
    logic       rs1_sel;
    logic       rs2_sel;
    logic [3:0] alu_sel;
    logic       is_br;
    logic       is_jal;
    logic       is_jalr;
    logic       br_inv;
    logic [4:0] rd;
  } ctrl_t;

  ctrl_t      dec;
  logic       dec_ill, dec_use1, dec_use2;
  logic [2:0] dec_imm;
  logic [2:0] f3;
  logic       f7b;
  logic       unused_instr;

  assign f3  = instr_D[14:12];
  assign f7b = instr_D[30];
  assign unused_instr = ^{instr_D[31], instr_D[29:25]};

  always_comb begin
    dec      = '0;
    dec_ill  = 1'b0;
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_imm  = 3'b000;
    dec.rd   = instr_D[11:7];
    case (instr_D[6:0])
      OP_R: begin
        dec.we = 1'b1; dec.wb_sel = 2'b01; dec.alu_sel = {f7b, f3};
        dec_use1 = 1'b1; dec_use2 = 1'b1;
      end
      OP_I: begin
        dec.we = 1'b1; dec.wb_sel = 2'b01; dec.rs2_sel = 1'b1;
        // funct7[5] only distinguishes SRAI from SRLI; it is immediate bits elsewhere
        dec.alu_sel = {(f3 == 3'b101) ? f7b : 1'b0, f3};
        dec_use1 = 1'b1;
      end
      OP_LD: begin
        dec.we = 1'b1; dec.wb_sel = 2'b00; dec.mem_re = 1'b1; dec.rs2_sel = 1'b1;
        dec_use1 = 1'b1;
      end
      OP_ST: begin
        dec.mem_we = 1'b1; dec.rs2_sel = 1'b1;
        dec_use1 = 1'b1; dec_use2 = 1'b1; dec_imm = 3'b001;
      end
      OP_BR: begin
        dec.is_br = 1'b1; dec.rs1_sel = 1'b1;
        // BEQ/BNE compare with SUB, BLT/BGE with SLT, BLTU/BGEU with SLTU
        dec.alu_sel = f3[2] ? {3'b001, f3[1]} : 4'b1000;
        dec.br_inv  = f3[2] ? ~f3[0] : f3[0];
        dec_use1 = 1'b1; dec_use2 = 1'b1; dec_imm = 3'b010;
      end
      OP_LUI: begin
        dec.we = 1'b1; dec.wb_sel = 2'b10; dec.rs2_sel = 1'b1; dec_imm = 3'b011;
      end
      OP_AUIPC: begin
        dec.we = 1'b1; dec.wb_sel = 2'b01; dec.rs1_sel = 1'b1; dec.rs2_sel = 1'b1;
        dec_imm = 3'b011;
      end
      OP_JAL: begin
        dec.we = 1'b1; dec.wb_sel = 2'b11; dec.is_jal = 1'b1;
        dec.rs1_sel = 1'b1; dec.rs2_sel = 1'b1; dec_imm = 3'b100;
      end
      OP_JALR: begin
        dec.we = 1'b1; dec.wb_sel = 2'b11; dec.is_jalr = 1'b1; dec.rs2_sel = 1'b1;
        dec_use1 = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  logic          vld_D_q, vld_E_q, vld_M_q, vld_W_q;
  ctrl_t         ctl_E_q;
  logic          we_M_q, mem_we_M_q, mem_re_M_q, jal_M_q, jalr_M_q, taken_M_q;
  logic [1:0]    wb_sel_M_q;
  logic [4:0]    rd_M_q;
  logic          we_W_q;
  logic [1:0]    wb_sel_W_q;
  logic [FW-1:0] flush_cnt_q;
  logic          illegal_q;

  logic taken_E, redirect, hz_E, hz_M, stall;

  assign taken_E  = alu_zero_E ^ ctl_E_q.br_inv;
  assign redirect = vld_M_q & (taken_M_q | jal_M_q | jalr_M_q);

  // WB is not checked: the regfile writes on the falling edge, so D reads the new value
  assign hz_E = vld_E_q & ctl_E_q.we & (ctl_E_q.rd != 5'd0) &
                ((dec_use1 & (ctl_E_q.rd == instr_D[19:15])) |
                 (dec_use2 & (ctl_E_q.rd == instr_D[24:20])));
  assign hz_M = vld_M_q & we_M_q & (rd_M_q != 5'd0) &
                ((dec_use1 & (rd_M_q == instr_D[19:15])) |
                 (dec_use2 & (rd_M_q == instr_D[24:20])));
  // A redirect squashes the stalled instruction anyway, so it overrides the stall
  assign stall = HAZARD_EN & vld_D_q & (hz_E | hz_M) & ~redirect;

  always_ff @(posedge clk or posedge reset_D) begin
    if (reset_D) begin
      vld_D_q     <= 1'b0;
      vld_E_q     <= 1'b0;
      ctl_E_q     <= '0;
      vld_M_q     <= 1'b0;
      we_M_q      <= 1'b0;
      wb_sel_M_q  <= 2'b00;
      mem_we_M_q  <= 1'b0;
      mem_re_M_q  <= 1'b0;
      jal_M_q     <= 1'b0;
      jalr_M_q    <= 1'b0;
      taken_M_q   <= 1'b0;
      rd_M_q      <= 5'd0;
      vld_W_q     <= 1'b0;
      we_W_q      <= 1'b0;
      wb_sel_W_q  <= 2'b00;
      flush_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      // The instruction fetched in the redirect cycle lands in D next cycle: drop it
      vld_D_q <= ~redirect;

      if (redirect || stall || !vld_D_q) begin
        vld_E_q <= 1'b0;
        ctl_E_q <= '0;
      end else begin
        vld_E_q <= 1'b1;
        ctl_E_q <= dec;
      end

      if (redirect || !vld_E_q) begin
        vld_M_q    <= 1'b0;
        we_M_q     <= 1'b0;
        wb_sel_M_q <= 2'b00;
        mem_we_M_q <= 1'b0;
        mem_re_M_q <= 1'b0;
        jal_M_q    <= 1'b0;
        jalr_M_q   <= 1'b0;
        taken_M_q  <= 1'b0;
        rd_M_q     <= 5'd0;
      end else begin
        vld_M_q    <= 1'b1;
        we_M_q     <= ctl_E_q.we;
        wb_sel_M_q <= ctl_E_q.wb_sel;
        mem_we_M_q <= ctl_E_q.mem_we;
        mem_re_M_q <= ctl_E_q.mem_re;
        jal_M_q    <= ctl_E_q.is_jal;
        jalr_M_q   <= ctl_E_q.is_jalr;
        taken_M_q  <= ctl_E_q.is_br & taken_E;
        rd_M_q     <= ctl_E_q.rd;
      end

      // The redirecting instruction itself retires (JAL/JALR still write rd)
      vld_W_q    <= vld_M_q;
      we_W_q     <= we_M_q;
      wb_sel_W_q <= wb_sel_M_q;

      if (redirect) begin
        flush_cnt_q <= FW'(FLUSH_LEN);
      end else if (flush_cnt_q != '0) begin
        flush_cnt_q <= flush_cnt_q - FW'(1);
      end

      illegal_q <= illegal_q | (vld_D_q & ~stall & ~redirect & dec_ill);
    end
  end

  assign imm_SEL = vld_D_q ? dec_imm : 3'b000;
  assign rs1_SEL = vld_E_q & ctl_E_q.rs1_sel;
  assign rs2_SEL = vld_E_q & ctl_E_q.rs2_sel;
  assign ALU_SEL = vld_E_q ? ctl_E_q.alu_sel : 4'b0000;
  assign pc_SEL  = redirect ? {~jalr_M_q, 1'b1} : 2'b00;
  assign mem_WE  = vld_M_q & mem_we_M_q;
  assign mem_RE  = vld_M_q & mem_re_M_q;
  assign reg_WE  = vld_W_q & we_W_q;
  assign reg_SEL = vld_W_q ? wb_sel_W_q : 2'b00;
  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_D = (flush_cnt_q != '0);
  assign flush_E = (flush_cnt_q != '0);
  assign flush_M = (flush_cnt_q != '0);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BAD   = 7'b0001011;

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] ADD_X2_X1  = 32'h00108133;
  localparam logic [31:0] ADDI_X0_1  = 32'h00100013;
  localparam logic [31:0] ADD_X3_X0  = 32'h000001B3;
  localparam logic [31:0] BEQ_P8     = 32'h00000463;
  localparam logic [31:0] BNE_P8     = 32'h00001463;
  localparam logic [31:0] SW_X1      = 32'h00102023;
  localparam logic [31:0] JALR_X1_X5 = 32'h000280E7;

  logic        clk = 1'b0;
  logic        reset_D;
  logic [31:0] instr_D;
  logic        alu_zero_E;
  logic [2:0]  imm_SEL;
  logic        rs1_SEL, rs2_SEL;
  logic [3:0]  ALU_SEL;
  logic [1:0]  pc_SEL;
  logic        mem_WE, mem_RE, reg_WE;
  logic [1:0]  reg_SEL;
  logic        stall_F, stall_D, flush_D, flush_E, flush_M, illegal;

  always #5 clk = ~clk;

  pipe_ctrl #(.HAZARD_EN(1'b1), .FLUSH_LEN(1)) dut (
    .clk(clk), .reset_D(reset_D), .instr_D(instr_D), .alu_zero_E(alu_zero_E),
    .imm_SEL(imm_SEL), .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .ALU_SEL(ALU_SEL),
    .pc_SEL(pc_SEL), .mem_WE(mem_WE), .mem_RE(mem_RE), .reg_WE(reg_WE),
    .reg_SEL(reg_SEL), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .flush_E(flush_E), .flush_M(flush_M), .illegal(illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: raw instruction words occupying each stage
  logic        r_dv, r_ev, r_mv, r_mt, r_wv, r_fl, r_ill;
  logic [31:0] r_ei, r_mi, r_wi;
  logic        e_redir, e_stall, obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic writes(input logic [31:0] i);
    case (i[6:0])
      OP_R, OP_I, OP_LD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic known(input logic [31:0] i);
    return writes(i) || i[6:0] == OP_ST || i[6:0] == OP_BR;
  endfunction

  function automatic logic reads1(input logic [31:0] i);
    case (i[6:0])
      OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads2(input logic [31:0] i);
    return i[6:0] == OP_R || i[6:0] == OP_ST || i[6:0] == OP_BR;
  endfunction

  function automatic logic depends(input logic v, input logic [31:0] p, input logic [31:0] d);
    logic [4:0] rd;
    rd = p[11:7];
    return v && writes(p) && rd != 5'd0 &&
           ((reads1(d) && rd == d[19:15]) || (reads2(d) && rd == d[24:20]));
  endfunction

  function automatic logic [2:0] imm_fmt(input logic [31:0] i);
    case (i[6:0])
      OP_ST:            return 3'b001;
      OP_BR:            return 3'b010;
      OP_LUI, OP_AUIPC: return 3'b011;
      OP_JAL:           return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_op(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    case (i[6:0])
      OP_R: return {i[30], f3};
      OP_I: return {(f3 == 3'd5) ? i[30] : 1'b0, f3};
      OP_BR: begin
        if (f3 == 3'd0 || f3 == 3'd1) return 4'b1000;
        if (f3 == 3'd4 || f3 == 3'd5) return 4'b0010;
        return 4'b0011;
      end
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] wb_src(input logic [31:0] i);
    case (i[6:0])
      OP_R, OP_I, OP_AUIPC: return 2'b01;
      OP_LUI:               return 2'b10;
      OP_JAL, OP_JALR:      return 2'b11;
      default:              return 2'b00;
    endcase
  endfunction

  // BEQ/BGE/BGEU take on a zero ALU result, BNE/BLT/BLTU on a nonzero one
  function automatic logic br_taken(input logic [31:0] i, input logic z);
    case (i[14:12])
      3'd0, 3'd5, 3'd7: return z;
      default:          return !z;
    endcase
  endfunction

  task automatic model_reset();
    r_dv = 0; r_ev = 0; r_mv = 0; r_mt = 0; r_wv = 0; r_fl = 0; r_ill = 0;
    r_ei = NOP; r_mi = NOP; r_wi = NOP;
  endtask

  task automatic check_outputs();
    e_redir = r_mv && (r_mt || r_mi[6:0] == OP_JAL || r_mi[6:0] == OP_JALR);
    e_stall = r_dv && (depends(r_ev, r_ei, instr_D) || depends(r_mv, r_mi, instr_D)) && !e_redir;
    chk("stall_F", stall_F, e_stall);
    chk("stall_D", stall_D, e_stall);
    chk("imm_SEL", imm_SEL, r_dv ? imm_fmt(instr_D) : 3'b000);
    chk("rs1_SEL", rs1_SEL, r_ev && (r_ei[6:0] == OP_AUIPC || r_ei[6:0] == OP_JAL || r_ei[6:0] == OP_BR));
    chk("rs2_SEL", rs2_SEL, r_ev && writes(r_ei) && r_ei[6:0] != OP_R || r_ev && r_ei[6:0] == OP_ST);
    chk("ALU_SEL", ALU_SEL, r_ev ? alu_op(r_ei) : 4'b0000);
    chk("pc_SEL", pc_SEL, e_redir ? {r_mi[6:0] != OP_JALR, 1'b1} : 2'b00);
    chk("mem_WE", mem_WE, r_mv && r_mi[6:0] == OP_ST);
    chk("mem_RE", mem_RE, r_mv && r_mi[6:0] == OP_LD);
    chk("reg_WE", reg_WE, r_wv && writes(r_wi));
    chk("reg_SEL", reg_SEL, r_wv ? wb_src(r_wi) : 2'b00);
    chk("flush_D", flush_D, r_fl);
    chk("flush_E", flush_E, r_fl);
    chk("flush_M", flush_M, r_fl);
    chk("illegal", illegal, r_ill);
  endtask

  task automatic cycle(input logic [31:0] ins, input logic z);
    instr_D = ins;
    alu_zero_E = z;
    @(negedge clk);
    check_outputs();
    obs_stall = stall_D;
    @(posedge clk);
    r_ill = r_ill | (r_dv && !e_stall && !e_redir && !known(ins));
    r_fl  = e_redir;
    r_wv  = r_mv;  r_wi = r_mi;
    r_mt  = (r_ei[6:0] == OP_BR) && br_taken(r_ei, z);
    r_mv  = r_ev && !e_redir;  r_mi = r_ei;
    r_ev  = r_dv && !e_stall && !e_redir;  r_ei = ins;
    r_dv  = !e_redir;
    #1;
  endtask

  // Presents one instruction, holding it in Decode for as long as the DUT stalls
  task automatic issue(input logic [31:0] ins, input logic z, output int stalls);
    stalls = 0;
    cycle(ins, z);
    while (obs_stall && stalls < 4) begin
      stalls++;
      cycle(ins, z);
    end
  endtask

  task automatic pulse_reset();
    reset_D = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset_D = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int r;
    i = $urandom;
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    r = $urandom_range(0, 39);
    case (r % 9)
      0: i[6:0] = OP_R;   1: i[6:0] = OP_I;     2: i[6:0] = OP_LD;
      3: i[6:0] = OP_ST;  4: i[6:0] = OP_BR;    5: i[6:0] = OP_LUI;
      6: i[6:0] = OP_AUIPC; 7: i[6:0] = OP_JAL; default: i[6:0] = OP_JALR;
    endcase
    if (r == 39) i[6:0] = OP_BAD;
    if (i[6:0] == OP_BR) begin
      case ($urandom_range(0, 5))
        0: i[14:12] = 3'd0; 1: i[14:12] = 3'd1; 2: i[14:12] = 3'd4;
        3: i[14:12] = 3'd5; 4: i[14:12] = 3'd6; default: i[14:12] = 3'd7;
      endcase
    end
    return i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset_D = 1'b1;
    instr_D = NOP;
    alu_zero_E = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset_D = 1'b0;

    cycle(NOP, 0);
    issue(ADDI_X1_5, 0, n);
    issue(ADD_X2_X1, 0, n);
    chk("raw_stall_cycles", n, 2);
    repeat (4) issue(NOP, 0, n);

    issue(ADDI_X0_1, 0, n);
    issue(ADD_X3_X0, 0, n);
    chk("x0_no_stall", n, 0);
    repeat (4) issue(NOP, 0, n);

    issue(BEQ_P8, 1, n);
    issue(ADDI_X1_5, 1, n);
    issue(SW_X1, 1, n);
    repeat (4) issue(NOP, 1, n);

    issue(BNE_P8, 1, n);
    issue(ADDI_X1_5, 1, n);
    issue(SW_X1, 1, n);
    repeat (4) issue(NOP, 1, n);

    issue(JALR_X1_X5, 0, n);
    issue(ADDI_X1_5, 0, n);
    repeat (5) issue(NOP, 0, n);

    // Reset lands while add x2 stalls behind addi x1 and a not-taken beq sits in M
    cycle(BEQ_P8, 0);
    cycle(ADDI_X1_5, 0);
    instr_D = ADD_X2_X1;
    #2;
    chk("stall_before_reset", stall_D, 1);
    pulse_reset();
    cycle(NOP, 0);
    issue(ADDI_X1_5, 0, n);
    issue(ADD_X2_X1, 0, n);
    chk("raw_stall_after_reset", n, 2);
    repeat (4) issue(NOP, 0, n);

    for (int k = 0; k < 400; k++) begin
      if (k == 200) pulse_reset();
      issue(rand_instr(), 1'($urandom_range(0, 1)), n);
      if (n > 2) chk("random_stall_bound", n, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
